// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Arbiter mode: free arbitration or a burst held by one requester.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Number of requesters sharing the memory port.
    localparam int NREQ = 2;

    // Width of the burst beat counter (bursts are limited to 1..15 beats).
    localparam int BEAT_W = 4;

    // A word access must have its two byte-offset bits clear.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-input round-robin picker used for free arbitration.
module rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            last_i,
    output logic [NREQ-1:0] gnt_o
);

    // A lone requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the load/store path (0) and a
// secondary master (1), with locked bursts capped at MAX_BURST beats.
//
// Handshake: a requester raises reqN and holds its address/data/we stable
// until it sees gntN high in the same cycle; the access is performed in that
// cycle and a write commits on the rising edge that ends it. gntN never rises
// without reqN, and gnt0/gnt1 are never high together.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output arb_state_t  fsm_state_o
);

    localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BURST);

    arb_state_t        fsm_q, fsm_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [NREQ-1:0]   err_q, err_d;

    logic [NREQ-1:0]   req, lock, rr_gnt, gnt;
    logic              owner_beat, any_gnt, sel, misal;
    logic [31:0]       sel_a, sel_wd;
    logic              sel_we;
    logic [BEAT_W-1:0] beats_inc;

    assign req  = {req1, req0};
    assign lock = {lock1, lock0};

    rr_pick u_rr_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

    // The burst owner keeps the port while it requests; otherwise arbitrate freely.
    always_comb begin
        gnt        = '0;
        owner_beat = reset && (fsm_q == LOCKED) && req[owner_q];
        if (reset) begin
            if (owner_beat) begin
                gnt[owner_q] = 1'b1;
            end else begin
                gnt = rr_gnt;
            end
        end
    end

    assign any_gnt = |gnt;
    assign sel     = gnt[1];

    // Route the granted requester onto the memory port; misaligned writes are dropped.
    always_comb begin
        sel_a  = sel ? a1  : a0;
        sel_wd = sel ? wd1 : wd0;
        sel_we = sel ? we1 : we0;
        misal  = any_gnt && is_misaligned(sel_a[1:0]);
        mem_we = any_gnt && sel_we && !misal;
        mem_a  = any_gnt ? {sel_a[31:2], 2'b00} : 32'h0;
        mem_wd = any_gnt ? sel_wd : 32'h0;
        rd0    = gnt[0] ? mem_rd : 32'h0;
        rd1    = gnt[1] ? mem_rd : 32'h0;
    end

    assign beats_inc = beats_q + BEAT_W'(1);

    // Next-state: round-robin history, burst entry/continuation/exit, sticky errors.
    always_comb begin
        fsm_d   = fsm_q;
        last_d  = last_q;
        owner_d = owner_q;
        beats_d = beats_q;
        err_d   = err_q;
        if (any_gnt) begin
            last_d = sel;
            if (misal) begin
                err_d[sel] = 1'b1;
            end
            if (owner_beat) begin
                // Burst continues only while lock is held and the cap is not reached.
                if (lock[owner_q] && (beats_inc < MAX_B)) begin
                    beats_d = beats_inc;
                end else begin
                    fsm_d   = IDLE;
                    beats_d = '0;
                end
            end else if (lock[sel] && (MAX_B > BEAT_W'(1))) begin
                // The granted beat counts as the first of the burst.
                fsm_d   = LOCKED;
                owner_d = sel;
                beats_d = BEAT_W'(1);
            end else begin
                fsm_d   = IDLE;
                beats_d = '0;
            end
        end else begin
            fsm_d   = IDLE;
            beats_d = '0;
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            beats_q <= '0;
            err_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    assign gnt0        = gnt[0];
    assign gnt1        = gnt[1];
    assign err0        = err_q[0];
    assign err1        = err_q[1];
    assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a directed cycle table followed by random traffic
// checked against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAXB = 4;
  localparam logic [31:0] A0 = 32'h0000_0010, A1 = 32'h0000_0020;
  localparam logic [31:0] W0 = 32'h0000_0011, W1 = 32'h0000_0022;

  typedef struct {
    logic rst, r0, r1, l0, l1, w0, w1;
    logic [31:0] a0, a1, wd0, wd1;
  } stim_t;

  typedef struct {
    stim_t s;
    logic g0, g1, we;
    logic [31:0] ma, mwd;
    logic e0, e1, lk;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic req0, req1, lock0, lock1, we0, we1;
  logic [31:0] a0, a1, wd0, wd1;
  logic gnt0, gnt1, err0, err1, mem_we;
  logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;
  arb_state_t fsm_state;

  // memory read data is a fixed function of the word address
  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    return {~addr[31:16], addr[15:0]} ^ 32'h1357_9BDF;
  endfunction
  assign mem_rd = mem_fn(mem_a);

  dmem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rd0(rd0), .rd1(rd1),
    .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .fsm_state_o(fsm_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // behavioural model: -1 means no burst owner
  int m_last, m_owner, m_beats;
  logic [1:0] m_err;

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_beats = 0; m_err = 2'b00;
  endtask

  // one clock cycle: drive, predict, compare, advance model
  task automatic run_cycle(input stim_t s, input bit use_tbl, input vec_t v);
    int g;
    logic [1:0] rq, lk;
    logic [31:0] ga, gwd, e_ma, e_mwd;
    logic gw, misal, e_g0, e_g1, e_we, e_e0, e_e1, e_lk;
    @(negedge clk);
    rst_n = s.rst; req0 = s.r0; req1 = s.r1; lock0 = s.l0; lock1 = s.l1;
    we0 = s.w0; we1 = s.w1; a0 = s.a0; a1 = s.a1; wd0 = s.wd0; wd1 = s.wd1;
    #2;
    if (!s.rst) model_reset();
    rq = {s.r1, s.r0};
    lk = {s.l1, s.l0};
    g = -1;
    if (s.rst) begin
      if (m_owner >= 0 && rq[m_owner]) g = m_owner;
      else if (rq == 2'b11) g = 1 - m_last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
    end
    ga  = (g == 1) ? s.a1 : s.a0;
    gwd = (g == 1) ? s.wd1 : s.wd0;
    gw  = (g == 1) ? s.w1 : s.w0;
    misal = (g >= 0) && (ga % 4 != 0);
    e_g0  = (g == 0);
    e_g1  = (g == 1);
    e_we  = (g >= 0) && gw && !misal;
    e_ma  = (g >= 0) ? ga - (ga % 4) : 32'h0;
    e_mwd = (g >= 0) ? gwd : 32'h0;
    e_e0  = m_err[0];
    e_e1  = m_err[1];
    e_lk  = (m_owner >= 0);
    if (use_tbl) begin
      e_g0 = v.g0; e_g1 = v.g1; e_we = v.we; e_ma = v.ma; e_mwd = v.mwd;
      e_e0 = v.e0; e_e1 = v.e1; e_lk = v.lk;
    end
    check("gnt0", 32'(gnt0), 32'(e_g0));
    check("gnt1", 32'(gnt1), 32'(e_g1));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_a", mem_a, e_ma);
    check("mem_wd", mem_wd, e_mwd);
    check("rd0", rd0, e_g0 ? mem_fn(e_ma) : 32'h0);
    check("rd1", rd1, e_g1 ? mem_fn(e_ma) : 32'h0);
    check("err0", 32'(err0), 32'(e_e0));
    check("err1", 32'(err1), 32'(e_e1));
    check("locked", 32'(fsm_state == LOCKED), 32'(e_lk));
    // state after the rising edge that ends this cycle
    if (s.rst) begin
      if (g >= 0) begin
        if (misal) m_err[g] = 1'b1;
        if (!lk[g]) begin
          m_owner = -1;
        end else begin
          m_beats = (m_owner == g) ? m_beats + 1 : 1;
          m_owner = (m_beats >= MAXB) ? -1 : g;
        end
        m_last = g;
      end else begin
        m_owner = -1;
      end
    end
    cyc++;
  endtask

  function automatic vec_t mk(input logic rst, r0, r1, l0, l1, w0, w1,
                              input logic [31:0] va0, va1, vwd0, vwd1,
                              input logic g0, g1, we, input logic [31:0] ma, mwd,
                              input logic e0, e1, lkd);
    vec_t v;
    v.s.rst = rst; v.s.r0 = r0; v.s.r1 = r1; v.s.l0 = l0; v.s.l1 = l1;
    v.s.w0 = w0; v.s.w1 = w1; v.s.a0 = va0; v.s.a1 = va1; v.s.wd0 = vwd0; v.s.wd1 = vwd1;
    v.g0 = g0; v.g1 = g1; v.we = we; v.ma = ma; v.mwd = mwd;
    v.e0 = e0; v.e1 = e1; v.lk = lkd;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    stim_t s;
    vec_t dummy;
    rst_n = 1'b1; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
    model_reset();
    #1 rst_n = 1'b0;

    //                rst r0 r1 l0 l1 w0 w1  a0           a1           wd0           wd1        g0 g1 we ma           mwd          e0 e1 lk
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    // alternating grants on a sustained tie
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 0));
    // requester 1 burst capped at MAX_BURST beats
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 0, 0, 0));
    // owner drops req in beat 2: requester 0 granted in the same cycle
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    // misaligned write from requester 0
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 32'h6, A1, 32'hDEAD_BEEF, W1,             1, 0, 0, 32'h4, 32'hDEAD_BEEF, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 0, 0, 32'h0, 32'h0, 1, 0, 0));
    // aligned peripheral write from requester 1
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, A0, 32'hC000_0004, W0, 32'h3FF,           0, 1, 1, 32'hC000_0004, 32'h3FF, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 0, 0, 32'h0, 32'h0, 1, 0, 0));
    // reset in beat 3 of a requester 0 burst
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 1, A0, A1, W0, W1,                           0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           1, 0, 0, A0, W0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 0));
    // lock dropped: that beat still goes to the owner
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, A0, A1, W0, W1,                           0, 1, 0, A1, W1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, A0, A1, W0, W1,                           1, 0, 1, A0, W0, 0, 0, 0));

    foreach (tbl[i]) run_cycle(tbl[i].s, 1'b1, tbl[i]);

    // random traffic against the model
    dummy = tbl[0];
    for (int i = 0; i < 400; i++) begin
      s.rst = ($urandom_range(0, 49) != 0);
      s.r0 = $urandom_range(0, 3) != 0;
      s.r1 = $urandom_range(0, 3) != 0;
      s.l0 = $urandom_range(0, 1);
      s.l1 = $urandom_range(0, 1);
      s.w0 = $urandom_range(0, 1);
      s.w1 = $urandom_range(0, 1);
      s.a0 = $urandom();
      s.a1 = $urandom();
      if ($urandom_range(0, 7) != 0) s.a0[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) s.a1[1:0] = 2'b00;
      s.wd0 = $urandom();
      s.wd1 = $urandom();
      run_cycle(s, 1'b0, dummy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
